ex_muldiv_iter: RTL

Parametrised iterative multiply/divide unit for the EX stage of the MIPS pipeline. It replaces the separate fixed-width mul/div instances with one engine covering MULT, MULTU, DIV and DIVU. It exposes a start/done handshake and drives the EX stall request while busy. Results are a HI/LO pair consumed by the HI/LO write path in MEM/WB.

---
 rtl/ex_muldiv_iter_pkg.sv | 35 +++
 rtl/ex_muldiv_iter_if.sv | 39 +++
 rtl/ex_muldiv_iter_md_abs.sv | 20 ++
 rtl/ex_muldiv_iter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_iter_pkg
//  Brief    : Shared op codes, FSM states and helpers for the iterative
//             EX-stage multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package ex_muldiv_iter_pkg;

  // Operation select, encoded as the EX decoder drives it.
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  // Engine state.
  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10,
    MD_DONE  = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_iter_if
//  Brief    : Start/done handshake, operands and HI/LO results of the
//             iterative multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_iter_if
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             annul;
  logic             busy;
  logic             stallreq;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  // EX stage side: issues operations and consumes results.
  modport master (
    output start, op, opa, opb, annul,
    input  busy, stallreq, done, result_hi, result_lo, div_by_zero
  );

  // Engine side.
  modport slave (
    input  start, op, opa, opb, annul,
    output busy, stallreq, done, result_hi, result_lo, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/ex_muldiv_iter_md_abs.sv
`default_nettype none
// ============================================================================
//  Module   : md_abs
//  Brief    : Conditional two's-complement negation (magnitude / sign fixup).
//  Revision : 1.0  initial release
// ============================================================================
module md_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign out_val = neg ? ((~in_val) + ONE) : in_val;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_iter
//  Brief    : Iterative MULT/MULTU/DIV/DIVU engine for the EX stage. One bit
//             per cycle on operand magnitudes, sign fixup in a final cycle,
//             HI/LO results held until the next completion.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_iter
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit DBZ_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_iter_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;       // raw dividend, returned as HI on divide by zero
  logic [WIDTH-1:0]   opm_q, opm_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or dividend/quotient in the low half
  logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder (always below the divisor)
  logic               neg_q, neg_d;       // negate product / quotient in FIXUP
  logic               rneg_q, rneg_d;     // negate remainder in FIXUP
  logic               dbz_op_q, dbz_op_d; // divide with a zero divisor in flight
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               dbz_q, dbz_d;

  logic in_fixup;
  logic idle_or_done;
  logic accept;
  logic in_signed;
  logic in_div;
  assign in_fixup     = (state_q == MD_FIXUP);
  assign idle_or_done = (state_q == MD_IDLE) || (state_q == MD_DONE);
  assign accept       = idle_or_done && bus.start && !bus.annul;
  assign in_signed    = op_is_signed(bus.op);
  assign in_div       = op_is_div(bus.op);

  // The two WIDTH negators serve operand magnitudes at launch and
  // quotient/remainder sign correction in FIXUP.
  logic [WIDTH-1:0]   abs_a_in, abs_a_val;
  logic [WIDTH-1:0]   abs_b_in, abs_b_val;
  logic               abs_a_neg, abs_b_neg;
  logic [2*WIDTH-1:0] prod_fix;

  assign abs_a_in  = in_fixup ? acc_q[WIDTH-1:0] : bus.opa;
  assign abs_a_neg = in_fixup ? neg_q  : (in_signed && bus.opa[WIDTH-1]);
  assign abs_b_in  = in_fixup ? rem_q  : bus.opb;
  assign abs_b_neg = in_fixup ? rneg_q : (in_signed && bus.opb[WIDTH-1]);

  md_abs #(.WIDTH(WIDTH)) u_abs_a (.in_val(abs_a_in), .neg(abs_a_neg), .out_val(abs_a_val));
  md_abs #(.WIDTH(WIDTH)) u_abs_b (.in_val(abs_b_in), .neg(abs_b_neg), .out_val(abs_b_val));
  md_abs #(.WIDTH(2*WIDTH)) u_abs_p (.in_val(acc_q), .neg(neg_q), .out_val(prod_fix));

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc LSB) is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opm_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  assign div_shift    = {rem_q, acc_q[WIDTH-1]};
  assign div_trial    = div_shift - {1'b0, opm_q};
  assign div_ge       = ~div_trial[WIDTH];
  assign div_rem_next = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

  // Next-state, datapath and result register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opm_d    = opm_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_op_d = dbz_op_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (accept) begin
          op_d     = bus.op;
          opa_d    = bus.opa;
          cnt_d    = '0;
          rem_d    = '0;
          neg_d    = in_signed && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
          rneg_d   = in_signed && bus.opa[WIDTH-1];
          dbz_op_d = in_div && (bus.opb == '0);
          dbz_d    = 1'b0;
          if (in_div) begin
            opm_d = abs_b_val;
            acc_d = {{WIDTH{1'b0}}, abs_a_val};
          end else begin
            opm_d = abs_a_val;
            acc_d = {{WIDTH{1'b0}}, abs_b_val};
          end
          if (DBZ_FAST && in_div && (bus.opb == '0)) begin
            state_d  = MD_DONE;
            res_lo_d = '1;
            res_hi_d = bus.opa;
            dbz_d    = 1'b1;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (bus.annul) begin
          state_d = MD_IDLE;
        end else begin
          if (op_is_div(op_q)) begin
            rem_d = div_rem_next;
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = MD_FIXUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MD_FIXUP: begin
        if (bus.annul) begin
          state_d = MD_IDLE;
        end else begin
          state_d = MD_DONE;
          if (op_is_div(op_q)) begin
            if (dbz_op_q) begin
              res_lo_d = '1;
              res_hi_d = opa_q;
              dbz_d    = 1'b1;
            end else begin
              res_lo_d = abs_a_val;
              res_hi_d = abs_b_val;
            end
          end else begin
            {res_hi_d, res_lo_d} = prod_fix;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MULTU;
      opa_q    <= '0;
      opm_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_op_q <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opm_q    <= opm_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_op_q <= dbz_op_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == MD_CALC) || in_fixup;
  assign bus.stallreq    = accept || bus.busy;
  assign bus.done        = (state_q == MD_DONE);
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire
